// File: rtl/x_pkg.sv
// Shared types and opcode constants for the X-channel command arbiter and controller.
package x_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } x_arb_state_t;

  localparam logic [3:0] X_OP_ADDR = 4'h0;
  localparam logic [3:0] X_OP_DATA = 4'h1;
  localparam logic [3:0] X_OP_WR   = 4'h2;
  localparam logic [3:0] X_OP_RD   = 4'h3;
  localparam logic [3:0] X_OP_PLAY = 4'h4;
  localparam logic [3:0] X_OP_ADV  = 4'h5;
  localparam logic [3:0] X_OP_ATOP = 4'h6;

  function automatic logic x_is_rd(input logic [7:0] cmd);
    return (cmd[7:4] == X_OP_RD);
  endfunction

endpackage

// File: rtl/x_tag_fifo.sv
// Outstanding-read tag FIFO: remembers which port issued each read, in issue order.
module x_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still honoured.
  always_comb begin
    o_full  = (count == (AW+1)'(DEPTH));
    o_empty = (count == '0);
    do_pop  = i_pop && !o_empty;
    do_push = i_push && (!o_full || do_pop);
    o_dout  = mem[rd_ptr];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= i_din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/x_cmd_arb.sv
// Two-port command arbiter in front of x_ctrl: sequence-granular grants, round-robin ties,
// idle-timeout revocation and tag-based routing of read responses.
module x_cmd_arb
  import x_pkg::*;
#(
  parameter int RD_DEPTH = 4,
  parameter int IDLE_TO  = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_a_valid,
  input  logic [7:0] i_a_cmd,
  input  logic       i_a_last,
  output logic       o_a_ready,
  output logic       o_a_rsp_valid,
  output logic [7:0] o_a_rsp,
  input  logic       i_b_valid,
  input  logic [7:0] i_b_cmd,
  input  logic       i_b_last,
  output logic       o_b_ready,
  output logic       o_b_rsp_valid,
  output logic [7:0] o_b_rsp,
  output logic       o_cmd_valid,
  output logic [7:0] o_cmd,
  input  logic       i_rsp_valid,
  input  logic [7:0] i_rsp,
  output logic       o_owner,
  output logic       o_busy,
  output logic       o_rsp_err
);

  localparam int CNT_W = (IDLE_TO > 0) ? $clog2(IDLE_TO + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(IDLE_TO);

  x_arb_state_t     state;
  logic             last_srv;
  logic [CNT_W-1:0] idle_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_head;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_cmd;
  logic             hold;
  logic             xfer;
  logic             push;
  logic             pop;

  // Read bytes wait while every tag slot is taken, unless a response frees one this cycle.
  always_comb begin
    sel_valid = 1'b0;
    sel_cmd   = 8'h00;
    sel_last  = 1'b0;
    case (state)
      GNT_A: begin
        sel_valid = i_a_valid;
        sel_cmd   = i_a_cmd;
        sel_last  = i_a_last;
      end
      GNT_B: begin
        sel_valid = i_b_valid;
        sel_cmd   = i_b_cmd;
        sel_last  = i_b_last;
      end
      default: begin
        sel_valid = 1'b0;
      end
    endcase
    hold      = x_is_rd(sel_cmd) && fifo_full && !i_rsp_valid;
    o_a_ready = (state == GNT_A) && !hold;
    o_b_ready = (state == GNT_B) && !hold;
    xfer      = sel_valid && (state != IDLE) && !hold;
    push      = xfer && x_is_rd(sel_cmd);
    pop       = i_rsp_valid && !fifo_empty;
    o_busy    = (state != IDLE);
    o_owner   = (state == GNT_B);
  end

  x_tag_fifo #(.DEPTH(RD_DEPTH)) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_din   (state == GNT_B),
    .i_pop   (pop),
    .o_dout  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      last_srv      <= 1'b1;
      idle_cnt      <= '0;
      o_cmd_valid   <= 1'b0;
      o_cmd         <= 8'h00;
      o_a_rsp_valid <= 1'b0;
      o_a_rsp       <= 8'h00;
      o_b_rsp_valid <= 1'b0;
      o_b_rsp       <= 8'h00;
      o_rsp_err     <= 1'b0;
    end else begin
      o_cmd_valid <= xfer;
      if (xfer) begin
        o_cmd <= sel_cmd;
      end
      o_a_rsp_valid <= pop && !fifo_head;
      o_b_rsp_valid <= pop && fifo_head;
      if (pop && !fifo_head) begin
        o_a_rsp <= i_rsp;
      end
      if (pop && fifo_head) begin
        o_b_rsp <= i_rsp;
      end
      o_rsp_err <= i_rsp_valid && fifo_empty;

      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (i_a_valid && (!i_b_valid || last_srv)) begin
            state <= GNT_A;
          end else if (i_b_valid) begin
            state <= GNT_B;
          end
        end
        GNT_A, GNT_B: begin
          if (xfer) begin
            idle_cnt <= '0;
            if (sel_last) begin
              state    <= IDLE;
              last_srv <= (state == GNT_B);
            end
          end else if (!sel_valid && (IDLE_TO != 0)) begin
            // Count reaches IDLE_TO on this edge: release so the grant drops IDLE_TO cycles after entry.
            if (idle_cnt >= TO_VAL - CNT_W'(1)) begin
              idle_cnt <= TO_VAL;
              state    <= IDLE;
              last_srv <= (state == GNT_B);
            end else begin
              idle_cnt <= idle_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x_cmd_arb.sv
// Directed bench for x_cmd_arb: queue-based reference model compared every cycle,
// plus literal expectations taken from the documented scenarios.
module tb_x_cmd_arb;

  localparam int RD_DEPTH = 4;
  localparam int IDLE_TO  = 16;

  logic       clk;
  logic       rst;
  logic       a_valid, a_last, a_ready, a_rsp_valid;
  logic [7:0] a_cmd, a_rsp;
  logic       b_valid, b_last, b_ready, b_rsp_valid;
  logic [7:0] b_cmd, b_rsp;
  logic       cmd_valid, rsp_valid, owner, busy, rsp_err;
  logic [7:0] cmd, rsp;

  int checks = 0;
  int errors = 0;

  x_cmd_arb #(.RD_DEPTH(RD_DEPTH), .IDLE_TO(IDLE_TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .i_a_cmd(a_cmd), .i_a_last(a_last), .o_a_ready(a_ready),
    .o_a_rsp_valid(a_rsp_valid), .o_a_rsp(a_rsp),
    .i_b_valid(b_valid), .i_b_cmd(b_cmd), .i_b_last(b_last), .o_b_ready(b_ready),
    .o_b_rsp_valid(b_rsp_valid), .o_b_rsp(b_rsp),
    .o_cmd_valid(cmd_valid), .o_cmd(cmd),
    .i_rsp_valid(rsp_valid), .i_rsp(rsp),
    .o_owner(owner), .o_busy(busy), .o_rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // grant: 0 none, 1 port A, 2 port B; tags hold the issuing port of each outstanding read
  int         m_grant  = 0;
  bit         m_last_b = 1'b1;
  int         m_idle   = 0;
  int         m_tags[$];
  bit         m_live   = 1'b0;
  bit         m_cmd_valid = 1'b0, m_a_rv = 1'b0, m_b_rv = 1'b0, m_err = 1'b0;
  logic [7:0] m_cmd = 8'h00, m_a_r = 8'h00, m_b_r = 8'h00;
  bit         m_ta, m_tb, m_gv, m_gl;
  int         m_g, m_tag;

  function automatic bit exp_ready(input int p);
    logic [7:0] c;
    if (m_grant != p) return 1'b0;
    c = (p == 1) ? a_cmd : b_cmd;
    if (c[7:4] == 4'h3 && m_tags.size() >= RD_DEPTH && !rsp_valid) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_grant = 0; m_last_b = 1'b1; m_idle = 0; m_tags.delete();
      m_cmd_valid = 1'b0; m_cmd = 8'h00; m_a_rv = 1'b0; m_a_r = 8'h00;
      m_b_rv = 1'b0; m_b_r = 8'h00; m_err = 1'b0; m_live = 1'b1;
    end else begin
      m_ta = a_valid && exp_ready(1);
      m_tb = b_valid && exp_ready(2);
      m_cmd_valid = m_ta || m_tb;
      if (m_ta) m_cmd = a_cmd;
      else if (m_tb) m_cmd = b_cmd;
      m_a_rv = 1'b0; m_b_rv = 1'b0; m_err = 1'b0;
      if (rsp_valid) begin
        if (m_tags.size() == 0) m_err = 1'b1;
        else begin
          m_tag = m_tags.pop_front();
          if (m_tag == 1) begin m_a_rv = 1'b1; m_a_r = rsp; end
          else begin m_b_rv = 1'b1; m_b_r = rsp; end
        end
      end
      if (m_ta && a_cmd[7:4] == 4'h3) m_tags.push_back(1);
      if (m_tb && b_cmd[7:4] == 4'h3) m_tags.push_back(2);
      m_g = m_grant;
      if (m_g == 0) begin
        m_idle = 0;
        if (a_valid && (!b_valid || m_last_b)) m_grant = 1;
        else if (b_valid) m_grant = 2;
      end else begin
        m_gv = (m_g == 1) ? a_valid : b_valid;
        m_gl = (m_g == 1) ? a_last : b_last;
        if (m_ta || m_tb) begin
          m_idle = 0;
          if (m_gl) begin m_grant = 0; m_last_b = (m_g == 2); end
        end else if (!m_gv && IDLE_TO > 0) begin
          m_idle++;
          if (m_idle >= IDLE_TO) begin m_grant = 0; m_last_b = (m_g == 2); end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("busy", busy, m_grant != 0);
      if (m_grant != 0) chk("owner", owner, m_grant == 2);
      chk("a_ready", a_ready, exp_ready(1));
      chk("b_ready", b_ready, exp_ready(2));
      chk("cmd_valid", cmd_valid, m_cmd_valid);
      if (m_cmd_valid) chk("cmd", cmd, m_cmd);
      chk("a_rsp_valid", a_rsp_valid, m_a_rv);
      if (m_a_rv) chk("a_rsp", a_rsp, m_a_r);
      chk("b_rsp_valid", b_rsp_valid, m_b_rv);
      if (m_b_rv) chk("b_rsp", b_rsp, m_b_r);
      chk("rsp_err", rsp_err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  logic [8:0] a_q[$];
  logic [8:0] b_q[$];
  logic [7:0] log_q[$];
  logic [7:0] exp_log[$];
  int         ncyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present queued {last,cmd} entries on both ports until all are accepted.
  task automatic run(input int max_cyc, output int used);
    bit ta, tb;
    used = 0;
    log_q.delete();
    while ((a_q.size() > 0 || b_q.size() > 0) && used < max_cyc) begin
      a_valid = (a_q.size() > 0);
      if (a_valid) {a_last, a_cmd} = a_q[0];
      b_valid = (b_q.size() > 0);
      if (b_valid) {b_last, b_cmd} = b_q[0];
      #1;
      ta = a_valid && a_ready;
      tb = b_valid && b_ready;
      tick();
      used++;
      if (ta) void'(a_q.pop_front());
      if (tb) void'(b_q.pop_front());
      if (cmd_valid) log_q.push_back(cmd);
    end
    a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
    if (a_q.size() > 0 || b_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL run_timeout: %0d bytes left after %0d cycles", a_q.size() + b_q.size(), used);
      a_q.delete(); b_q.delete();
    end
  endtask

  task automatic chk_log(input string name);
    chk({name, "_len"}, 8'(log_q.size()), 8'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < log_q.size(); i++) chk(name, log_q[i], exp_log[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; a_valid = 1'b0; a_cmd = 8'h00; a_last = 1'b0;
    b_valid = 1'b0; b_cmd = 8'h00; b_last = 1'b0; rsp_valid = 1'b0; rsp = 8'h00;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    rst = 1'b0;
    tick();

    // A alone: five bytes, one per cycle after a one-cycle grant
    a_q = '{9'h001, 9'h002, 9'h003, 9'h015, 9'h120};
    run(50, ncyc);
    exp_log = '{8'h01, 8'h02, 8'h03, 8'h15, 8'h20};
    chk_log("a_alone");
    chk("a_alone_cycles", 8'(ncyc), 8'd6);
    chk("a_alone_busy_drop", busy, 1'b0);
    tick();

    // Both valid from reset: A, B, then A wins the next tie
    rst = 1'b1; tick(); rst = 1'b0;
    a_q = '{9'h001, 9'h112, 9'h007, 9'h128};
    b_q = '{9'h005, 9'h126, 9'h009, 9'h12B};
    run(80, ncyc);
    exp_log = '{8'h01, 8'h12, 8'h05, 8'h26, 8'h07, 8'h28, 8'h09, 8'h2B};
    chk_log("rr_order");
    chk("rr_cycles", 8'(ncyc), 8'd12);
    tick();

    // B reads, then A reads; responses return in issue order
    b_q = '{9'h130};
    run(20, ncyc);
    a_q = '{9'h130};
    run(20, ncyc);
    rsp_valid = 1'b1; rsp = 8'h2A;
    tick();
    chk("route_b_valid", b_rsp_valid, 1'b1);
    chk("route_b_data", b_rsp, 8'h2A);
    chk("route_b_a_quiet", a_rsp_valid, 1'b0);
    rsp = 8'h11;
    tick();
    chk("route_a_valid", a_rsp_valid, 1'b1);
    chk("route_a_data", a_rsp, 8'h11);
    chk("route_a_b_quiet", b_rsp_valid, 1'b0);
    rsp_valid = 1'b0;
    tick();

    // Tag FIFO full: fifth read is held until a response frees a slot
    a_q = '{9'h030, 9'h030, 9'h030, 9'h030};
    run(20, ncyc);
    a_valid = 1'b1; a_cmd = 8'h30; a_last = 1'b1;
    #1;
    chk("full_hold", a_ready, 1'b0);
    tick(); tick();
    chk("full_hold_still", a_ready, 1'b0);
    chk("full_hold_busy", busy, 1'b1);
    rsp_valid = 1'b1; rsp = 8'h55;
    #1;
    chk("full_release", a_ready, 1'b1);
    tick();
    a_valid = 1'b0; a_last = 1'b0;
    chk("full_cmd_valid", cmd_valid, 1'b1);
    chk("full_cmd", cmd, 8'h30);
    chk("full_rsp_valid", a_rsp_valid, 1'b1);
    chk("full_rsp", a_rsp, 8'h55);
    chk("full_last_idle", busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rsp = 8'h60 + 8'(k);
      tick();
      chk("drain_valid", a_rsp_valid, 1'b1);
      chk("drain_data", a_rsp, 8'h60 + 8'(k));
    end
    rsp_valid = 1'b0;
    tick();

    // Idle timeout: A granted but silent while B waits
    a_valid = 1'b1; a_cmd = 8'h01; a_last = 1'b0;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b1; b_cmd = 8'h25; b_last = 1'b1;
    #1;
    chk("to_grant_busy", busy, 1'b1);
    chk("to_grant_owner", owner, 1'b0);
    chk("to_b_waits", b_ready, 1'b0);
    for (int k = 0; k < 15; k++) tick();
    chk("to_g15_busy", busy, 1'b1);
    tick();
    chk("to_g16_revoked", busy, 1'b0);
    tick();
    chk("to_b_busy", busy, 1'b1);
    chk("to_b_owner", owner, 1'b1);
    chk("to_b_ready", b_ready, 1'b1);
    tick();
    b_valid = 1'b0; b_last = 1'b0;
    chk("to_b_cmd", cmd, 8'h25);
    chk("to_b_done", busy, 1'b0);
    tick();

    // Response with nothing outstanding
    rsp_valid = 1'b1; rsp = 8'h77;
    tick();
    rsp_valid = 1'b0;
    chk("err_pulse", rsp_err, 1'b1);
    chk("err_no_a", a_rsp_valid, 1'b0);
    chk("err_no_b", b_rsp_valid, 1'b0);
    tick();
    chk("err_one_cycle", rsp_err, 1'b0);

    // Reset in the middle of a held sequence with a read outstanding
    a_q = '{9'h030};
    run(20, ncyc);
    a_valid = 1'b1; a_cmd = 8'h01;
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_a_ready", a_ready, 1'b0);
    chk("mid_rst_cmd_valid", cmd_valid, 1'b0);
    chk("mid_rst_cmd", cmd, 8'h00);
    chk("mid_rst_a_rsp", a_rsp, 8'h00);
    chk("mid_rst_b_rsp", b_rsp, 8'h00);
    chk("mid_rst_owner", owner, 1'b0);
    rst = 1'b0; a_valid = 1'b0;
    tick();
    rsp_valid = 1'b1; rsp = 8'h99;
    tick();
    rsp_valid = 1'b0;
    chk("mid_rst_fifo_empty", rsp_err, 1'b1);
    chk("mid_rst_tag_gone", a_rsp_valid, 1'b0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
